// File: rtl/hash_pkg.sv
// hash_pkg: definitions shared by the receive-side hash_checker and the
// transmit-side hasher, so both ends agree on seed, rotation and sizing.
//   HASH_W    : hash state width
//   MAX_BYTES : largest payload in bytes
//   DEF_SEED  : default initial hash state
//   DEF_ROT   : default left-rotate distance per round (legal 1..31)
//   state_t   : checker FSM encoding
package hash_pkg;

   localparam int          HASH_W    = 32;
   localparam int          MAX_BYTES = 8;
   localparam logic [31:0] DEF_SEED  = 32'h0000_0000;
   localparam int          DEF_ROT   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HASH = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/hash_round.sv
// hash_round: one combinational hash round, h_next = rotl(h, ROT) ^ byte.
// Used by both the checker and the transmit-side hasher.
//   h_i      : current hash state
//   byte_i   : payload byte folded into the state
//   h_next_o : updated hash state
module hash_round #(
   parameter int ROT = 5
) (
   input  logic [31:0] h_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] h_next_o
);

   logic [31:0] rot;

   // Bits shifted out of the top re-enter at bit 0.
   assign rot      = (h_i << ROT) | (h_i >> (32 - ROT));
   assign h_next_o = rot ^ {24'b0, byte_i};

endmodule

// File: rtl/hash_checker.sv
// hash_checker: accepts a payload (up to 8 bytes), its length and the
// transmitted hash; recomputes the hash one byte per cycle and reports the
// result with a valid/ready handshake.
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : payload handshake (accepted only in IDLE)
//   data, data_len    : payload, byte k = data[8k+7:8k]; length 0..8
//   expected_hash     : hash sent alongside the payload
//   result_valid/ready: result handshake; outputs hold until taken
//   hash_out, match   : recomputed hash, equality with expected_hash
//   len_err           : data_len was greater than 8
module hash_checker
   import hash_pkg::*;
#(
   parameter logic [31:0] SEED = DEF_SEED,
   parameter int          ROT  = DEF_ROT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] data,
   input  logic [3:0]  data_len,
   input  logic [31:0] expected_hash,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [31:0] hash_out,
   output logic        match,
   output logic        len_err
);

   state_t      state_q;
   logic        in_ready_q, rv_q, match_q, lerr_q;
   logic [31:0] hash_q, h_q, exp_q;
   logic [63:0] data_q;
   logic [3:0]  len_q;
   logic [2:0]  cnt_q;

   logic [7:0]  byte_cur;
   logic [31:0] h_next, fin;
   logic        last;

   assign byte_cur = data_q[{cnt_q, 3'b000} +: 8];
   assign fin      = h_next ^ {28'b0, len_q};
   assign last     = ({1'b0, cnt_q} == (len_q - 4'd1));

   hash_round #(.ROT(ROT)) u_round (
      .h_i      (h_q),
      .byte_i   (byte_cur),
      .h_next_o (h_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b1;
         rv_q       <= 1'b0;
         hash_q     <= '0;
         match_q    <= 1'b0;
         lerr_q     <= 1'b0;
         h_q        <= SEED;
         cnt_q      <= '0;
         data_q     <= '0;
         len_q      <= '0;
         exp_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  data_q     <= data;
                  len_q      <= data_len;
                  exp_q      <= expected_hash;
                  h_q        <= SEED;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  if (data_len > 4'(MAX_BYTES)) begin
                     state_q <= DONE;
                     rv_q    <= 1'b1;
                     lerr_q  <= 1'b1;
                     match_q <= 1'b0;
                     hash_q  <= SEED;
                  end else if (data_len == 4'd0) begin
                     // Empty payload: hash is the seed, finalisation xor is 0.
                     state_q <= DONE;
                     rv_q    <= 1'b1;
                     lerr_q  <= 1'b0;
                     match_q <= (SEED == expected_hash);
                     hash_q  <= SEED;
                  end else begin
                     state_q <= HASH;
                     lerr_q  <= 1'b0;
                  end
               end
            end
            HASH: begin
               h_q   <= h_next;
               cnt_q <= cnt_q + 3'd1;
               if (last) begin
                  state_q <= DONE;
                  rv_q    <= 1'b1;
                  hash_q  <= fin;
                  match_q <= (fin == exp_q);
               end
            end
            DONE: begin
               if (result_ready) begin
                  state_q    <= IDLE;
                  rv_q       <= 1'b0;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               rv_q       <= 1'b0;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign result_valid = rv_q;
   assign hash_out     = hash_q;
   assign match        = match_q;
   assign len_err      = lerr_q;

endmodule

// File: tb/tb_hash_checker.sv
module tb_hash_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] data;
   logic [3:0]  data_len;
   logic [31:0] expected_hash;
   logic        result_valid;
   logic        result_ready;
   logic [31:0] hash_out;
   logic        match;
   logic        len_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hash_checker dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .data          (data),
      .data_len      (data_len),
      .expected_hash (expected_hash),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .hash_out      (hash_out),
      .match         (match),
      .len_err       (len_err)
   );

   typedef struct {
      logic [63:0] data;
      logic [3:0]  len;
      logic [31:0] exp;
      logic [31:0] e_hash;
      logic        e_match;
      logic        e_lerr;
      int          e_lat;
      int          hold;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, req);
      end
   endtask

   // Offer a payload, measure latency (accept edge counts as 1), optionally
   // stall the result while offering a conflicting payload, then take it.
   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      logic [31:0] h0;
      logic m0, l0;
      @(negedge clk);
      chk($sformatf("v%0d in_ready_idle", idx), {31'b0, in_ready}, 32'd1);
      data = v.data; data_len = v.len; expected_hash = v.exp; in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      in_valid = 1'b0; data = ~v.data; expected_hash = ~v.exp;
      @(negedge clk);
      while (!result_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk($sformatf("v%0d latency", idx), lat, v.e_lat);
      chk($sformatf("v%0d hash_out", idx), hash_out, v.e_hash);
      chk($sformatf("v%0d match", idx), {31'b0, match}, {31'b0, v.e_match});
      chk($sformatf("v%0d len_err", idx), {31'b0, len_err}, {31'b0, v.e_lerr});
      h0 = hash_out; m0 = match; l0 = len_err;
      if (v.hold > 0) begin
         in_valid = 1'b1; data = 64'h0303; data_len = 4'd2; expected_hash = 32'h1;
      end
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d hold%0d stable", idx, i),
             {hash_out[28:0] ^ h0[28:0], match ^ m0, len_err ^ l0, ~result_valid}, 32'd0);
         chk($sformatf("v%0d hold%0d in_ready", idx, i), {31'b0, in_ready}, 32'd0);
         chk($sformatf("v%0d hold%0d hash_hi", idx, i), {29'b0, hash_out[31:29]}, {29'b0, h0[31:29]});
      end
      in_valid = 1'b0;
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d rv_after_take", idx), {31'b0, result_valid}, 32'd0);
      chk($sformatf("v%0d ready_after_take", idx), {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      //         data                    len    exp           hash          m     le    lat hold
      vecs[0] = '{64'h0201,              4'd2,  32'h20,       32'h20,       1'b1, 1'b0, 3, 0};
      vecs[1] = '{64'h0,                 4'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
      vecs[2] = '{64'hFF,                4'd1,  32'h0,        32'hFE,       1'b0, 1'b0, 2, 0};
      vecs[3] = '{64'h0101_0101_0101_0101, 4'd8, 32'h42108421, 32'h42108421, 1'b1, 1'b0, 9, 0};
      vecs[4] = '{64'hDEAD_BEEF,         4'd9,  32'h0,        32'h0,        1'b0, 1'b1, 1, 5};
      vecs[5] = '{64'h03_0201,           4'd3,  32'h440,      32'h440,      1'b1, 1'b0, 4, 2};
      vecs[6] = '{64'h1234,              4'd15, 32'h0,        32'h0,        1'b0, 1'b1, 1, 0};
      vecs[7] = '{64'h55,                4'd0,  32'h5,        32'h0,        1'b0, 1'b0, 1, 0};

      reset = 1'b1; in_valid = 1'b0; result_ready = 1'b0;
      data = '0; data_len = '0; expected_hash = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset result_valid", {31'b0, result_valid}, 32'd0);
      chk("reset in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset hash_out", hash_out, 32'd0);
      chk("reset match", {31'b0, match}, 32'd0);
      chk("reset len_err", {31'b0, len_err}, 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset in the middle of an 8-byte hash.
      @(negedge clk);
      data = 64'h0101_0101_0101_0101; data_len = 4'd8; expected_hash = 32'h42108421;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid in_ready_busy", {31'b0, in_ready}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid reset result_valid", {31'b0, result_valid}, 32'd0);
      chk("mid reset in_ready", {31'b0, in_ready}, 32'd1);
      run_vec(vecs[0], 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hash_checker.md
Name: hash_checker

Overview:
- Receive-side counterpart of the message hasher. Accepts a 64-bit payload, its byte length and the hash sent alongside it.
- Recomputes the hash one byte per cycle, then reports the computed hash and whether it matches the transmitted one.
- Sits at the consumer end of a hashed-message link and gates delivery of payloads that fail the check.

Parameters:
- SEED, 32'h0000_0000, initial hash state.
- ROT, 5, left-rotate distance per round; legal range 1..31.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  payload offered.
- in_ready  out  1  checker can accept a payload.
- data  in  64  payload; byte k is data[8k+7:8k], processed in order k=0 upward.
- data_len  in  4  number of valid bytes, 0..8.
- expected_hash  in  32  hash transmitted with the payload.
- result_valid  out  1  result available.
- result_ready  in  1  consumer takes the result.
- hash_out  out  32  recomputed hash.
- match  out  1  1 when hash_out equals expected_hash and len_err is 0.
- len_err  out  1  data_len was greater than 8.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: FSM goes to IDLE; result_valid=0, hash_out=0, match=0, len_err=0; internal h=SEED, count=0. in_ready=1 in the first cycle after reset deasserts.
- Round function: h_next = rotl(h, ROT) ^ {24'b0, byte}. All arithmetic is 32-bit; rotation wraps bits from 31 into 0.
- Finalisation: hash_out = h ^ {28'b0, data_len}.
- FSM states: IDLE, HASH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture data, data_len and expected_hash; set h=SEED and count=0.
  - If data_len>8: go to DONE with len_err=1, match=0, hash_out=SEED.
  - Else if data_len==0: go to DONE with hash_out=SEED.
  - Else: go to HASH.
- HASH:
  - in_ready=0.
  - Each cycle apply one round to byte[count], then count++.
  - The cycle that processes byte data_len-1 moves to DONE and registers hash_out and match from the updated h.
- DONE:
  - result_valid=1; in_ready=0.
  - hash_out, match and len_err hold stable while result_ready=0.
  - On result_ready: go to IDLE, result_valid=0 next cycle.
  - A new payload can be accepted no earlier than the cycle after the result is taken; there is no overlap.
- Latency: payload accepted on edge t gives result_valid high from edge t+data_len+1. data_len=0 and data_len>8 give edge t+1.
- Simultaneous events:
  - in_valid while not in IDLE is ignored; the sender must hold the payload.
  - reset wins over every other input.
- Reset mid-operation: any state returns to IDLE; partial hash discarded; result_valid drops in the same edge.
- Captured inputs are registered; changes on data and expected_hash after acceptance have no effect.

Decomposition:
- Shared package hash_pkg:
  - HASH_W=32, MAX_BYTES=8.
  - Default SEED and ROT.
  - State encoding constants IDLE/HASH/DONE.
  - Shared with the transmit-side hasher so both ends agree on seed and rotation.
- One sub-module hash_round: combinational rotl-and-xor, inputs h[31:0] and byte[7:0], parameter ROT, output h_next[31:0].
- The transmit hasher must instantiate the same hash_round.

Test Plan:
- data=64'h0201, data_len=2, expected=32'h20 -> hash_out=32'h20, match=1, result_valid 3 cycles after accept.
- data_len=0, expected=32'h0 -> hash_out=0, match=1, result_valid 1 cycle after accept.
- data=64'hFF, data_len=1, expected=32'h0 -> hash_out=32'hFE, match=0, len_err=0.
- data=64'h0101_0101_0101_0101, data_len=8, expected=32'h42108421 -> hash_out=32'h42108421, match=1. Exercises rotation wrap; result_valid 9 cycles after accept.
- data_len=9 -> len_err=1, match=0, hash_out=SEED, result_valid 1 cycle after accept. Hold result_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
- Assert reset during HASH of an 8-byte payload -> next cycle result_valid=0, in_ready=1. A following len=2 payload 0x0201 still yields 32'h20.
